// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and FSM state type for the memory stage.
package mem_stage_pkg;

  localparam int RW      = 16;
  localparam int REGNO   = 8;
  localparam int TIMEOUT = 255;

  localparam logic MEM_WIDTH_WORD = 1'b0;
  localparam logic MEM_WIDTH_BYTE = 1'b1;

  typedef enum logic {
    MEMSTG_IDLE = 1'b0,
    MEMSTG_BUS  = 1'b1
  } memstg_state_t;

endpackage

// File: rtl/mem_stage.sv
// Memory pipeline stage: ALU write-back pass-through and data-bus load/store
// transactions with bus-error / timeout exception pulses back to execute.
module mem_stage #(
  parameter int RW      = mem_stage_pkg::RW,
  parameter int REGNO   = mem_stage_pkg::REGNO,
  parameter int TIMEOUT = mem_stage_pkg::TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  input  logic             i_mem_width,
  input  logic             i_data_page,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_exception,
  output logic             o_bus_req,
  output logic             o_bus_we,
  output logic [RW-1:0]    o_bus_addr,
  output logic [RW-1:0]    o_bus_data,
  output logic [1:0]       o_bus_sel,
  output logic             o_bus_paged,
  input  logic             i_bus_ack,
  input  logic [RW-1:0]    i_bus_data,
  input  logic             i_bus_err,
  output logic             o_dbg_state
);

  import mem_stage_pkg::memstg_state_t;
  import mem_stage_pkg::MEMSTG_IDLE;
  import mem_stage_pkg::MEMSTG_BUS;
  import mem_stage_pkg::MEM_WIDTH_WORD;
  import mem_stage_pkg::MEM_WIDTH_BYTE;

  // Handshake: a request is taken on a clock edge where i_submit && o_ready.
  // i_submit while o_ready is low is ignored. The bus holds o_bus_req until
  // i_bus_ack or i_bus_err is sampled high; err wins over ack.

  memstg_state_t    state, state_next;
  logic [7:0]       tmo_cnt;
  logic [REGNO-1:0] lat_reg_ie;
  logic             lat_width;
  logic             lat_lane;
  logic             timeout_hit;
  logic             bus_fault;
  logic             accept_mem;
  logic [7:0]       load_byte;
  logic [RW-1:0]    load_data;

  assign o_ready     = (state == MEMSTG_IDLE);
  assign o_dbg_state = state;

  assign timeout_hit = (tmo_cnt == 8'(TIMEOUT - 1));
  assign bus_fault   = i_bus_err || (timeout_hit && !i_bus_ack);
  assign accept_mem  = o_ready && i_submit && i_mem_access;

  // Lane extraction for byte loads; the latched address bit picks the lane.
  assign load_byte = lat_lane ? i_bus_data[15:8] : i_bus_data[7:0];
  assign load_data = (lat_width == MEM_WIDTH_WORD) ? i_bus_data
                                                   : {{(RW-8){1'b0}}, load_byte};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= MEMSTG_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      MEMSTG_IDLE: if (accept_mem) state_next = MEMSTG_BUS;
      MEMSTG_BUS:  if (i_bus_ack || bus_fault) state_next = MEMSTG_IDLE;
      default:     state_next = MEMSTG_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_reg_ie        <= '0;
      o_reg_data      <= '0;
      o_mem_exception <= 1'b0;
      o_bus_req       <= 1'b0;
      o_bus_we        <= 1'b0;
      o_bus_addr      <= '0;
      o_bus_data      <= '0;
      o_bus_sel       <= 2'b00;
      o_bus_paged     <= 1'b0;
      tmo_cnt         <= '0;
      lat_reg_ie      <= '0;
      lat_width       <= MEM_WIDTH_WORD;
      lat_lane        <= 1'b0;
    end else begin
      o_reg_ie        <= '0;
      o_mem_exception <= 1'b0;
      case (state)
        MEMSTG_IDLE: begin
          if (i_submit && !i_mem_access) begin
            o_reg_ie   <= i_reg_ie;
            o_reg_data <= i_data;
          end else if (accept_mem) begin
            o_bus_req   <= 1'b1;
            o_bus_we    <= i_mem_we;
            o_bus_addr  <= i_addr;
            o_bus_paged <= i_data_page;
            lat_reg_ie  <= i_reg_ie;
            lat_width   <= i_mem_width;
            lat_lane    <= i_addr[0];
            tmo_cnt     <= '0;
            if (i_mem_width == MEM_WIDTH_BYTE) begin
              o_bus_sel  <= i_addr[0] ? 2'b10 : 2'b01;
              o_bus_data <= {(RW/8){i_data[7:0]}};
            end else begin
              o_bus_sel  <= 2'b11;
              o_bus_data <= i_data;
            end
          end
        end
        MEMSTG_BUS: begin
          if (bus_fault) begin
            o_bus_req       <= 1'b0;
            o_mem_exception <= 1'b1;
          end else if (i_bus_ack) begin
            o_bus_req <= 1'b0;
            if (!o_bus_we) begin
              o_reg_ie   <= lat_reg_ie;
              o_reg_data <= load_data;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: o_bus_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU write-back, word/byte loads and stores,
// bus error, err+ack, timeout and mid-transaction reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        submit;
  logic        ready;
  logic [15:0] data;
  logic [15:0] addr;
  logic [7:0]  reg_ie_in;
  logic        mem_access;
  logic        mem_we;
  logic        mem_width;
  logic        data_page;
  logic [7:0]  reg_ie_out;
  logic [15:0] reg_data;
  logic        mem_exception;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [15:0] bus_wdata;
  logic [1:0]  bus_sel;
  logic        bus_paged;
  logic        bus_ack;
  logic [15:0] bus_rdata;
  logic        bus_err;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_rst(rst), .i_submit(submit), .o_ready(ready),
    .i_data(data), .i_addr(addr), .i_reg_ie(reg_ie_in),
    .i_mem_access(mem_access), .i_mem_we(mem_we), .i_mem_width(mem_width),
    .i_data_page(data_page), .o_reg_ie(reg_ie_out), .o_reg_data(reg_data),
    .o_mem_exception(mem_exception), .o_bus_req(bus_req), .o_bus_we(bus_we),
    .o_bus_addr(bus_addr), .o_bus_data(bus_wdata), .o_bus_sel(bus_sel),
    .o_bus_paged(bus_paged), .i_bus_ack(bus_ack), .i_bus_data(bus_rdata),
    .i_bus_err(bus_err), .o_dbg_state(dbg_state)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected write-back data popped in order
  task automatic chk_wb(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      e = 32'hDEAD_BEEF;
    end else begin
      e = exp_q.pop_front();
    end
    chk(tag, {16'h0, reg_data}, e);
  endtask

  task automatic idle_inputs();
    submit = 0; data = 0; addr = 0; reg_ie_in = 0; mem_access = 0;
    mem_we = 0; mem_width = 0; data_page = 0; bus_ack = 0; bus_rdata = 0; bus_err = 0;
  endtask

  task automatic issue_mem(input logic we, input logic width, input logic [15:0] a,
                           input logic [15:0] d, input logic [7:0] rie, input logic pg);
    submit = 1; mem_access = 1; mem_we = we; mem_width = width;
    addr = a; data = d; reg_ie_in = rie; data_page = pg;
    step();
    submit = 0; mem_access = 0;
  endtask

  initial begin : main
    int k;
    idle_inputs();
    rst = 1;
    step();
    step();
    chk("rst_ready", ready, 1);
    chk("rst_req", bus_req, 0);
    chk("rst_reg_ie", reg_ie_out, 0);
    chk("rst_exc", mem_exception, 0);
    chk("rst_sel", bus_sel, 0);
    rst = 0;
    step();

    // ALU write
    submit = 1; reg_ie_in = 8'h04; data = 16'h1234;
    exp_q.push_back(32'h1234);
    step();
    submit = 0;
    chk("alu_reg_ie", reg_ie_out, 8'h04);
    chk_wb("alu_data");
    step();
    chk("alu_reg_ie_drop", reg_ie_out, 0);

    // back-to-back ALU
    submit = 1; reg_ie_in = 8'h01; data = 16'h1111;
    exp_q.push_back(32'h1111);
    step();
    chk("b2b0_reg_ie", reg_ie_out, 8'h01);
    chk_wb("b2b0_data");
    reg_ie_in = 8'h80; data = 16'h2222;
    exp_q.push_back(32'h2222);
    step();
    submit = 0;
    chk("b2b1_reg_ie", reg_ie_out, 8'h80);
    chk_wb("b2b1_data");

    // word load, ack on third bus cycle; a stray submit during BUS is ignored
    issue_mem(0, 0, 16'h0200, 16'h0, 8'h08, 1);
    chk("wl_req", bus_req, 1);
    chk("wl_sel", bus_sel, 2'b11);
    chk("wl_addr", bus_addr, 16'h0200);
    chk("wl_we", bus_we, 0);
    chk("wl_paged", bus_paged, 1);
    chk("wl_ready", ready, 0);
    submit = 1; reg_ie_in = 8'h02; data = 16'h5555;
    step();
    chk("wl_wait1_req", bus_req, 1);
    chk("wl_wait1_ready", ready, 0);
    chk("wl_ignored_reg_ie", reg_ie_out, 0);
    step();
    chk("wl_wait2_ready", ready, 0);
    submit = 0;
    bus_ack = 1; bus_rdata = 16'hBEEF;
    exp_q.push_back(32'hBEEF);
    step();
    bus_ack = 0;
    chk("wl_req_drop", bus_req, 0);
    chk("wl_reg_ie", reg_ie_out, 8'h08);
    chk_wb("wl_data");
    chk("wl_ready_back", ready, 1);
    step();
    chk("wl_reg_ie_drop", reg_ie_out, 0);

    // byte store to odd address
    issue_mem(1, 1, 16'h0101, 16'h00A5, 8'h10, 0);
    chk("bs_sel", bus_sel, 2'b10);
    chk("bs_data", bus_wdata, 16'hA5A5);
    chk("bs_we", bus_we, 1);
    chk("bs_req", bus_req, 1);
    bus_ack = 1;
    step();
    bus_ack = 0;
    chk("bs_req_drop", bus_req, 0);
    chk("bs_no_wb", reg_ie_out, 0);
    step();
    chk("bs_no_wb2", reg_ie_out, 0);

    // byte load hi lane
    issue_mem(0, 1, 16'h0103, 16'h0, 8'h20, 0);
    chk("blh_sel", bus_sel, 2'b10);
    bus_ack = 1; bus_rdata = 16'h7F33;
    exp_q.push_back(32'h007F);
    step();
    bus_ack = 0;
    chk("blh_reg_ie", reg_ie_out, 8'h20);
    chk_wb("blh_data");

    // byte load lo lane, word store
    issue_mem(0, 1, 16'h0104, 16'h0, 8'h40, 0);
    chk("bll_sel", bus_sel, 2'b01);
    bus_ack = 1; bus_rdata = 16'h7F33;
    exp_q.push_back(32'h0033);
    step();
    bus_ack = 0;
    chk_wb("bll_data");
    issue_mem(1, 0, 16'h0300, 16'hC3A5, 8'h01, 0);
    chk("ws_data", bus_wdata, 16'hC3A5);
    chk("ws_sel", bus_sel, 2'b11);
    bus_ack = 1;
    step();
    bus_ack = 0;
    chk("ws_no_wb", reg_ie_out, 0);

    // bus error
    issue_mem(0, 0, 16'h0400, 16'h0, 8'h02, 0);
    bus_err = 1;
    step();
    bus_err = 0;
    chk("err_exc", mem_exception, 1);
    chk("err_no_wb", reg_ie_out, 0);
    chk("err_req", bus_req, 0);
    chk("err_ready", ready, 1);
    step();
    chk("err_exc_drop", mem_exception, 0);

    // err and ack together: err wins
    issue_mem(0, 0, 16'h0402, 16'h0, 8'h02, 0);
    bus_err = 1; bus_ack = 1; bus_rdata = 16'h1357;
    step();
    bus_err = 0; bus_ack = 0;
    chk("errack_exc", mem_exception, 1);
    chk("errack_no_wb", reg_ie_out, 0);
    step();
    chk("errack_exc_drop", mem_exception, 0);

    // timeout: exception expected after 255 unanswered bus cycles
    issue_mem(0, 0, 16'h0500, 16'h0, 8'h04, 0);
    k = 1;
    while (k <= 300) begin
      step();
      if (mem_exception) break;
      k++;
    end
    chk("tmo_cycles", k, 255);
    chk("tmo_req", bus_req, 0);
    chk("tmo_no_wb", reg_ie_out, 0);
    step();
    chk("tmo_exc_drop", mem_exception, 0);

    // reset mid-BUS
    issue_mem(0, 0, 16'h0600, 16'h0, 8'h08, 1);
    chk("rstbus_req", bus_req, 1);
    #2;
    rst = 1;
    #1;
    chk("rstbus_req_drop", bus_req, 0);
    chk("rstbus_ready", ready, 1);
    step();
    rst = 0;
    step();
    chk("rstbus_ready_after", ready, 1);
    chk("rstbus_addr", bus_addr, 0);
    chk("rstbus_paged", bus_paged, 0);
    chk("rstbus_reg_ie", reg_ie_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
